// File: rtl/cw_husky_top.sv
// Husky capture core: USB register bus, arm/trigger FSM and a sample FIFO fed by a 12-bit test counter.
// Bus inputs are registered, so writes land two cycles after WRn falls; there is no backpressure and the host paces the FIFO drain.
module cw_husky_top #(
  parameter int pFIFO_DEPTH = 1024,
  parameter int pCNT_WIDTH  = 12
) (
  input  logic       clk_usb,
  input  logic       reset_n,
  inout  wire  [7:0] USB_Data,
  input  logic [7:0] USB_Addr,
  input  logic       USB_RDn,
  input  logic       USB_WRn,
  input  logic       USB_CEn,
  input  logic       target_io4,
  output logic       LED_ARMED,
  output logic       LED_CAP,
  output logic       FPGA_TRIGOUT
);
  localparam int AW = $clog2(pFIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(pFIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t state;
  logic [7:0]  addr_s, addr_d, data_s, rd_dat;
  logic        rdn_s, rdn_d, wrn_s, wrn_d, cen_s, cen_d, trig_in_s;
  logic        wr_en, rd_done, rd3, rd_pop, trig_now, arm, arm_rise, trig_cond;
  logic [7:0]  gain, settings, scratch_4, scratch_38, scratch_60, scratch_61;
  logic [7:0]  data_src, soft_rst, read_mode, last_addr;
  logic [31:0] total_smp, pre_smp;
  logic [1:0]  byte_idx, wr_idx, rd_idx, bus_idx, rd_phase;
  logic [pCNT_WIDTH-1:0] tp_cnt, sample, head, nxt;
  logic [pCNT_WIDTH-1:0] mem [pFIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt, total_lim, pre_lim;
  logic          fifo_empty, filled, push, drop, pop, push_ok;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      addr_s <= '0; addr_d <= '0; data_s <= '0;
      rdn_s <= 1'b1; rdn_d <= 1'b1; wrn_s <= 1'b1; wrn_d <= 1'b1;
      cen_s <= 1'b1; cen_d <= 1'b1; trig_in_s <= 1'b0;
    end else begin
      addr_s <= USB_Addr; addr_d <= addr_s; data_s <= USB_Data;
      rdn_s <= USB_RDn; rdn_d <= rdn_s; wrn_s <= USB_WRn; wrn_d <= wrn_s;
      cen_s <= USB_CEn; cen_d <= cen_s; trig_in_s <= target_io4;
    end
  end

  assign wr_en   = !wrn_s && wrn_d && !cen_s;
  assign rd_done = rdn_s && !rdn_d && !cen_d;
  assign wr_idx  = (addr_s == last_addr) ? byte_idx : 2'd0;
  assign rd_idx  = (addr_d == last_addr) ? byte_idx : 2'd0;
  assign bus_idx = (USB_Addr == last_addr) ? byte_idx : 2'd0;

  assign arm       = settings[3];
  assign arm_rise  = wr_en && (addr_s == 8'd1) && data_s[3] && !arm;
  assign trig_cond = (trig_in_s == settings[2]) || trig_now;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      gain <= '0; settings <= '0; scratch_4 <= '0; scratch_38 <= '0;
      scratch_60 <= '0; scratch_61 <= '0; data_src <= '0; soft_rst <= '0;
      read_mode <= '0; total_smp <= '0; pre_smp <= '0; trig_now <= 1'b0;
    end else begin
      trig_now <= 1'b0;
      if (wr_en) begin
        case (addr_s)
          8'd0:  gain <= data_s;
          8'd1:  begin settings <= data_s & 8'hBF; trig_now <= data_s[6]; end
          8'd4:  scratch_4 <= data_s;
          8'd16: total_smp[{wr_idx, 3'b000} +: 8] <= data_s;
          8'd17: pre_smp[{wr_idx, 3'b000} +: 8] <= data_s;
          8'd27: data_src <= data_s;
          8'd28: soft_rst <= data_s;
          8'd29: read_mode <= data_s;
          8'd38: scratch_38 <= data_s;
          8'd60: scratch_60 <= data_s;
          8'd61: scratch_61 <= data_s;
          default: ;
        endcase
      end
    end
  end

  // Reg 3 in 12-bit mode walks a 3-byte phase; an empty FIFO at phase 0 leaves it parked.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      last_addr <= '0; byte_idx <= '0; rd_phase <= '0;
    end else if (soft_rst[0]) begin
      last_addr <= '0; byte_idx <= '0; rd_phase <= '0;
    end else if (wr_en) begin
      last_addr <= addr_s;
      byte_idx  <= wr_idx + 2'd1;
    end else if (rd_done) begin
      last_addr <= addr_d;
      byte_idx  <= rd_idx + 2'd1;
      if (addr_d == 8'd3 && !read_mode[0] && !(rd_phase == 2'd0 && fifo_empty))
        rd_phase <= (rd_phase == 2'd2) ? 2'd0 : rd_phase + 2'd1;
    end
  end

  assign total_lim  = (total_smp > 32'(pFIFO_DEPTH)) ? DEPTH : total_smp[AW:0];
  assign pre_lim    = (pre_smp > 32'(pFIFO_DEPTH)) ? DEPTH : pre_smp[AW:0];
  assign fifo_empty = (fifo_cnt == '0);
  assign filled     = (fifo_cnt == pre_lim);
  assign sample     = (data_src == 8'd0) ? tp_cnt : '0;
  assign head       = mem[rd_ptr];
  assign nxt        = mem[rd_ptr + AW'(1)];
  assign rd3        = rd_done && !wr_en && (addr_d == 8'd3);
  assign rd_pop     = rd3 && (read_mode[0] || rd_phase != 2'd0);

  // The trigger cycle itself stores a sample, so pretrigger data runs straight into capture.
  always_comb begin
    push = 1'b0;
    drop = 1'b0;
    case (state)
      ARMED: if (arm) begin
        if (filled && trig_cond) push = (fifo_cnt < total_lim);
        else if (pre_lim != '0) begin
          push = 1'b1;
          drop = filled;
        end
      end
      CAPTURE: push = arm && (fifo_cnt < total_lim);
      default: ;
    endcase
  end

  assign pop     = (drop || rd_pop) && !fifo_empty && !soft_rst[0];
  assign push_ok = push && (fifo_cnt != DEPTH || pop) && !soft_rst[0];

  always_ff @(posedge clk_usb) begin
    if (push_ok) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE; tp_cnt <= '0; wr_ptr <= '0; rd_ptr <= '0;
      fifo_cnt <= '0; FPGA_TRIGOUT <= 1'b0;
    end else if (soft_rst[0]) begin
      state <= IDLE; tp_cnt <= '0; wr_ptr <= '0; rd_ptr <= '0;
      fifo_cnt <= '0; FPGA_TRIGOUT <= 1'b0;
    end else begin
      tp_cnt       <= tp_cnt + pCNT_WIDTH'(1);
      FPGA_TRIGOUT <= 1'b0;
      if (state == IDLE && arm_rise) begin
        state <= ARMED; wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fifo_cnt <= fifo_cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        case (state)
          ARMED:
            if (!arm) state <= IDLE;
            else if (filled && trig_cond) begin
              state        <= CAPTURE;
              FPGA_TRIGOUT <= 1'b1;
            end
          CAPTURE:
            if (!arm) state <= IDLE;
            else if (fifo_cnt >= total_lim) state <= DONE;
          DONE: if (!arm) state <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign LED_ARMED = (state == ARMED);
  assign LED_CAP   = (state == CAPTURE);

  always_comb begin
    rd_dat = 8'h00;
    case (USB_Addr)
      8'd0:  rd_dat = gain;
      8'd1:  rd_dat = settings;
      8'd2:  rd_dat = {4'b0, fifo_empty, state == DONE, state == CAPTURE, state == ARMED};
      8'd3:
        if (!fifo_empty) begin
          if (read_mode[0]) rd_dat = head[7:0];
          else case (rd_phase)
            2'd0:    rd_dat = head[11:4];
            2'd1:    rd_dat = {head[3:0], (fifo_cnt > 1) ? nxt[11:8] : 4'h0};
            default: rd_dat = head[7:0];
          endcase
        end
      8'd4:  rd_dat = scratch_4;
      8'd16: rd_dat = total_smp[{bus_idx, 3'b000} +: 8];
      8'd17: rd_dat = pre_smp[{bus_idx, 3'b000} +: 8];
      8'd27: rd_dat = data_src;
      8'd28: rd_dat = soft_rst;
      8'd29: rd_dat = read_mode;
      8'd38: rd_dat = scratch_38;
      8'd60: rd_dat = scratch_60;
      8'd61: rd_dat = scratch_61;
      default: ;
    endcase
  end

  assign USB_Data = (!USB_CEn && !USB_RDn) ? rd_dat : 8'hzz;
endmodule

// File: tb/tb_cw_husky_top.sv
// Bench for cw_husky_top: bus-level register checks and capture sequences compared with counter arithmetic.
module tb_cw_husky_top;
  logic       clk_usb = 1'b0;
  logic       reset_n;
  wire  [7:0] USB_Data;
  logic [7:0] USB_Addr, drv_dat;
  logic       drv_en, USB_RDn, USB_WRn, USB_CEn, target_io4;
  wire        LED_ARMED, LED_CAP, FPGA_TRIGOUT;

  int n_chk, n_err, edge_n, trig_cnt, trig_edge;
  logic [11:0] got_q[$];

  assign USB_Data = drv_en ? drv_dat : 8'hzz;

  cw_husky_top dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .USB_Data(USB_Data), .USB_Addr(USB_Addr),
    .USB_RDn(USB_RDn), .USB_WRn(USB_WRn), .USB_CEn(USB_CEn), .target_io4(target_io4),
    .LED_ARMED(LED_ARMED), .LED_CAP(LED_CAP), .FPGA_TRIGOUT(FPGA_TRIGOUT)
  );

  always #5 clk_usb = ~clk_usb;

  // Free-running edge count since reset: the test counter value after edge n is n mod 4096.
  always @(posedge clk_usb or negedge reset_n)
    if (!reset_n) edge_n <= 0; else edge_n <= edge_n + 1;

  always @(negedge clk_usb)
    if (FPGA_TRIGOUT === 1'b1) begin
      trig_cnt  <= trig_cnt + 1;
      trig_edge <= edge_n;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_usb);
    USB_Addr = a; drv_dat = d; drv_en = 1'b1; USB_CEn = 1'b0; USB_WRn = 1'b0;
    @(negedge clk_usb);
    @(negedge clk_usb);
    USB_WRn = 1'b1;
    @(negedge clk_usb);
    USB_CEn = 1'b1; drv_en = 1'b0;
    @(negedge clk_usb);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk_usb);
    USB_Addr = a; USB_CEn = 1'b0; USB_RDn = 1'b0;
    @(negedge clk_usb);
    @(negedge clk_usb);
    d = USB_Data;
    USB_RDn = 1'b1;
    @(negedge clk_usb);
    @(negedge clk_usb);
    USB_CEn = 1'b1;
    @(negedge clk_usb);
  endtask

  task automatic do_reset();
    @(negedge clk_usb);
    reset_n = 1'b0; USB_CEn = 1'b1; USB_RDn = 1'b1; USB_WRn = 1'b1; drv_en = 1'b0;
    repeat (3) @(negedge clk_usb);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_usb);
  endtask

  task automatic wait_done(input string tag);
    logic [7:0] b;
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      bus_rd(8'd2, b);
      if (b[2]) ok = 1'b1;
    end
    chk({tag, "_done"}, {31'b0, ok}, 32'd1);
  endtask

  // Reads n samples back; 12-bit mode unpacks groups of three bytes into two samples.
  task automatic drain(input string tag, input int n, input bit m8);
    logic [7:0] b0, b1, b2;
    got_q.delete();
    if (m8) begin
      for (int i = 0; i < n; i++) begin
        bus_rd(8'd3, b0);
        got_q.push_back({4'h0, b0});
      end
    end else begin
      for (int g = 0; g < (n + 1) / 2; g++) begin
        bus_rd(8'd3, b0); bus_rd(8'd3, b1); bus_rd(8'd3, b2);
        got_q.push_back({b0, b1[7:4]});
        if (2 * g + 1 < n) got_q.push_back({b1[3:0], b2});
        else chk({tag, "_pad"}, {20'b0, b1[3:0], b2}, 32'd0);
      end
    end
  endtask

  task automatic check_seq(input string tag, input int first, input int mask);
    for (int i = 0; i < got_q.size(); i++) begin
      chk(tag, {20'b0, got_q[i]}, (first + i) & mask);
      if ({20'b0, got_q[i]} != ((first + i) & mask)) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b, v;
    logic [7:0] addrs[5];
    logic [7:0] vals[5];
    int t0, tv, n;
    addrs = '{8'd0, 8'd4, 8'd38, 8'd60, 8'd61};
    reset_n = 1'b0; USB_Addr = '0; drv_dat = '0; drv_en = 1'b0;
    USB_RDn = 1'b1; USB_WRn = 1'b1; USB_CEn = 1'b1; target_io4 = 1'b0;
    do_reset();

    chk("rst_led_armed", {31'b0, LED_ARMED}, 32'd0);
    chk("rst_led_cap", {31'b0, LED_CAP}, 32'd0);
    chk("rst_trigout", {31'b0, FPGA_TRIGOUT}, 32'd0);
    bus_rd(8'd0, b); chk("rst_reg0", {24'b0, b}, 32'h00);
    bus_rd(8'd2, b); chk("rst_reg2", {24'b0, b}, 32'h08);

    bus_wr(8'd4, 8'hA5); bus_rd(8'd4, b); chk("reg4_a5", {24'b0, b}, 32'hA5);
    foreach (addrs[i]) begin
      vals[i] = 8'($urandom);
      bus_wr(addrs[i], vals[i]);
    end
    foreach (addrs[i]) begin
      bus_rd(addrs[i], b);
      chk("scratch", {24'b0, b}, {24'b0, vals[i]});
    end
    v = 8'($urandom_range(1, 255));
    bus_wr(8'd5, v); bus_rd(8'd5, b); chk("unmapped5", {24'b0, b}, 32'h00);
    bus_wr(8'd200, v); bus_rd(8'd200, b); chk("unmapped200", {24'b0, b}, 32'h00);

    bus_wr(8'd16, 8'd90); bus_wr(8'd16, 8'd0); bus_wr(8'd16, 8'd0); bus_wr(8'd16, 8'd0);
    bus_rd(8'd16, b); chk("reg16_b0", {24'b0, b}, 32'h5A);
    bus_rd(8'd16, b); chk("reg16_b1", {24'b0, b}, 32'h00);
    bus_rd(8'd16, b); chk("reg16_b2", {24'b0, b}, 32'h00);
    bus_rd(8'd16, b); chk("reg16_b3", {24'b0, b}, 32'h00);
    bus_rd(8'd16, b); chk("reg16_wrap", {24'b0, b}, 32'h5A);
    bus_rd(8'd4, b);
    bus_rd(8'd16, b); chk("reg16_idx_reset", {24'b0, b}, 32'h5A);
    bus_rd(8'd16, b); chk("reg16_idx_next", {24'b0, b}, 32'h00);

    // 8-bit readout, level trigger; trigger placed so the low byte wraps during capture.
    do_reset();
    bus_wr(8'd29, 8'd1); bus_wr(8'd16, 8'd90);
    target_io4 = 1'b0; t0 = trig_cnt;
    bus_wr(8'd1, 8'h0C);
    chk("t1_armed", {31'b0, LED_ARMED}, 32'd1);
    chk("t1_not_cap", {31'b0, LED_CAP}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      if ((edge_n & 255) == 200) break;
      @(negedge clk_usb);
    end
    repeat ($urandom_range(0, 20)) @(negedge clk_usb);
    target_io4 = 1'b1;
    wait_done("t1");
    chk("t1_trig_pulse", trig_cnt - t0, 32'd1);
    tv = (trig_edge - 1) & 12'hFFF;
    drain("t1", 90, 1'b1);
    check_seq("t1_byte", tv, 255);
    bus_rd(8'd2, b); chk("t1_reg2_done", {24'b0, b}, 32'h0C);
    bus_rd(8'd3, b); chk("t1_empty_rd", {24'b0, b}, 32'h00);
    bus_wr(8'd1, 8'h00);
    bus_rd(8'd2, b); chk("t1_idle", {24'b0, b}, 32'h08);

    // 12-bit readout, trigger-now.
    do_reset();
    bus_wr(8'd16, 8'd90);
    target_io4 = 1'b1; t0 = trig_cnt;
    bus_wr(8'd1, 8'h48);
    bus_rd(8'd1, b); chk("t2_reg1_rd", {24'b0, b}, 32'h08);
    wait_done("t2");
    chk("t2_trig_pulse", trig_cnt - t0, 32'd1);
    tv = (trig_edge - 1) & 12'hFFF;
    drain("t2", 90, 1'b0);
    chk("t2_count", got_q.size(), 32'd90);
    check_seq("t2_sample", tv, 12'hFFF);

    // Presamples 10, odd total so the last pair is padded.
    do_reset();
    n = 2 * $urandom_range(10, 25) + 1;
    bus_wr(8'd16, 8'(n)); bus_wr(8'd17, 8'd10);
    target_io4 = 1'b0; t0 = trig_cnt;
    bus_wr(8'd1, 8'h0C);
    repeat ($urandom_range(15, 40)) @(negedge clk_usb);
    chk("t3_no_early_trig", trig_cnt - t0, 32'd0);
    target_io4 = 1'b1;
    wait_done("t3");
    tv = (trig_edge - 1) & 12'hFFF;
    drain("t3", n, 1'b0);
    chk("t3_count", got_q.size(), n);
    check_seq("t3_sample", tv - 10, 12'hFFF);
    bus_rd(8'd2, b); chk("t3_reg2_done", {24'b0, b}, 32'h0C);

    // Soft reset in the middle of a capture, then a clean capture afterwards.
    bus_wr(8'd1, 8'h00); bus_wr(8'd17, 8'd0);
    bus_wr(8'd29, 8'd1); bus_wr(8'd16, 8'd200);
    target_io4 = 1'b1;
    bus_wr(8'd1, 8'h48);
    for (int i = 0; i < 20; i++) begin
      if (LED_CAP === 1'b1) break;
      @(negedge clk_usb);
    end
    chk("t4_cap_before", {31'b0, LED_CAP}, 32'd1);
    bus_wr(8'd28, 8'd1);
    chk("t4_cap_srst", {31'b0, LED_CAP}, 32'd0);
    bus_rd(8'd2, b); chk("t4_reg2_srst", {24'b0, b}, 32'h08);
    bus_rd(8'd3, b); chk("t4_reg3_srst", {24'b0, b}, 32'h00);
    bus_rd(8'd16, b); chk("t4_cfg_kept", {24'b0, b}, 32'd200);
    bus_wr(8'd28, 8'd0);
    bus_wr(8'd16, 8'd90);
    bus_wr(8'd1, 8'h00);
    t0 = trig_cnt;
    bus_wr(8'd1, 8'h48);
    wait_done("t4");
    chk("t4_trig_pulse", trig_cnt - t0, 32'd1);
    drain("t4", 90, 1'b1);
    check_seq("t4_byte", int'(got_q[0]), 255);
    bus_rd(8'd2, b); chk("t4_reg2_done", {24'b0, b}, 32'h0C);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
